// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix divider datapath and its result unloader.
// Holds the unloader state encoding, the error/trailer word constants and the default bus widths.
// Optional feature macro used by the unloader: UNLOAD_TRAILER_EN.
package matrix_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;

    localparam logic [31:0] ERR_WORD    = 32'hFFFF_FFFF;
    localparam logic [15:0] TRAILER_TAG = 16'hA5A5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        TRAILER = 2'd2,
        FIN     = 2'd3
    } unload_state_t;

    // Trailer layout: tag, element count, padding, det_zero flag.
    function automatic logic [31:0] trailer_word(input int n_elem, input logic det_zero);
        return {TRAILER_TAG, 8'(n_elem), 7'b0, det_zero};
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Output register for the result stream: word, valid, last and error flag.
// Latency: a load appears on the outputs the cycle after it is strobed.
// Backpressure: contents hold while valid && !ready; loads only land when the slot is free or draining.
module stream_out_reg
    import matrix_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              err_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              err_o,
    output logic              xfer_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;
    logic              err_q;
    logic              load_ok;
    logic              clr_ok;

    assign xfer_o  = valid_q && ready_i;
    // A word already on the bus can only be replaced on the cycle it is accepted.
    assign load_ok = load_i && (!valid_q || ready_i);
    assign clr_ok  = clr_i && xfer_o;

    // Output register: load a new word, drop valid after the final transfer, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (load_ok) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
            err_q   <= err_i;
        end else if (clr_ok) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign err_o   = err_q;

endmodule

// File: rtl/matrix_result_unloader.sv
// Streams the 2x2 result file MatrixR (row-major) after the matrix top's done pulse, or one error word if det(B)==0.
// Latency: first word valid 1 cycle after start; 1 word/cycle under full ready; done_unload 1 cycle after last transfer.
// Backpressure: words hold under !out_ready; start while busy is dropped and flagged on overrun. Macro: UNLOAD_TRAILER_EN.
module matrix_result_unloader
    import matrix_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_ELEM = 4,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              det_zero,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_err,
    output logic              busy,
    output logic              done_unload,
    output logic              overrun
);

    localparam int IDX_W = $clog2(N_ELEM + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM);

    unload_state_t     state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              err_q;
    logic              busy_q;
    logic              done_q;
    logic              overrun_q;

    logic              ld;
    logic              clr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_err;
    logic              xfer;
    logic              final_word;
    logic              last_data;

    // idx counts words already fetched, so it always addresses the next element to read.
    assign rd_addr    = ADDR_W'(BASE) + ADDR_W'(idx_q);
    assign final_word = err_q || (idx_q == LAST_IDX);

`ifdef UNLOAD_TRAILER_EN
    // The trailer carries the end-of-result marker, so data words never do.
    assign last_data = 1'b0;
`else
    localparam logic [IDX_W-1:0] PEN_IDX = IDX_W'(N_ELEM - 1);
    assign last_data = (idx_q == PEN_IDX);
`endif

    // Load/clear strobes into the output register, decoded from state and the current transfer.
    always_comb begin
        ld      = 1'b0;
        clr     = 1'b0;
        ld_data = '0;
        ld_last = 1'b0;
        ld_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ld = 1'b1;
                    if (det_zero) begin
                        ld_data = DATA_W'(ERR_WORD);
                        ld_last = 1'b1;
                        ld_err  = 1'b1;
                    end else begin
                        ld_data = rd_data;
                        ld_last = last_data;
                    end
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (final_word) begin
                        clr = 1'b1;
                    end else begin
                        ld      = 1'b1;
                        ld_data = rd_data;
                        ld_last = last_data;
                    end
                end
            end
`ifdef UNLOAD_TRAILER_EN
            TRAILER: begin
                if (!out_valid) begin
                    ld      = 1'b1;
                    ld_data = DATA_W'(trailer_word(N_ELEM, err_q));
                    ld_last = 1'b1;
                end else if (xfer) begin
                    clr = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // Sequencer: walks IDLE -> STREAM -> (TRAILER) -> FIN and registers busy/done/overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            overrun_q <= start && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        err_q   <= det_zero;
                        state_q <= STREAM;
                        // The error word does not come from MatrixR, so the address stays at BASE.
                        if (!det_zero) begin
                            idx_q <= IDX_W'(1);
                        end
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (final_word) begin
`ifdef UNLOAD_TRAILER_EN
                            if (!err_q) begin
                                state_q <= TRAILER;
                            end else begin
                                state_q <= FIN;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
`else
                            state_q <= FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
`ifdef UNLOAD_TRAILER_EN
                TRAILER: begin
                    if (xfer) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`endif
                FIN: begin
                    idx_q   <= '0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    stream_out_reg #(
        .DATA_W (DATA_W)
    ) u_out (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ld),
        .clr_i   (clr),
        .data_i  (ld_data),
        .last_i  (ld_last),
        .err_i   (ld_err),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .data_o  (out_data),
        .last_o  (out_last),
        .err_o   (out_err),
        .xfer_o  (xfer)
    );

    assign busy        = busy_q;
    assign done_unload = done_q;
    assign overrun     = overrun_q;

endmodule
